pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
- REQ-001 SHALL have parameter PC_W, default 10, program counter width in bits.
- REQ-002 SHALL have parameter CNT_W, default 16, retired-instruction counter width.
- REQ-003 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
- REQ-004 SHALL have ports: reset  in  1  asynchronous, active-high reset.
- REQ-005 SHALL have ports: req  in  1  start request from testbench/host.
- REQ-006 SHALL have ports: start_addr  in  PC_W  PC loaded on accepted req.
- REQ-007 SHALL have ports: branch  in  1  decoded branch (Control Branch).
- REQ-008 SHALL have ports: branch_taken  in  1  ALU condition flag.
- REQ-009 SHALL have ports: branch_target  in  PC_W  absolute target address.
- REQ-010 SHALL have ports: mem_access  in  1  decoded load or store (MemWrite | MemtoReg).
- REQ-011 SHALL have ports: halt_instr  in  1  decoded halt opcode.
- REQ-012 SHALL have ports: pc  out  PC_W  instruction-memory address; fetch_en  out  1  instruction-register load strobe.
- REQ-013 SHALL have ports: reg_we_gate  out  1  qualifies RegWrite; mem_we_gate  out  1  qualifies MemWrite.
- REQ-014 SHALL have ports: done  out  1  program finished; instr_count  out  CNT_W  retired instructions.

Function
- REQ-015 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, DONE.
- REQ-016 SHALL go IDLE->FETCH when req=1, loading pc<=start_addr and clearing instr_count to 0.
- REQ-017 SHALL assert fetch_en only in FETCH (one cycle); go FETCH->DECODE unconditionally.
- REQ-018 SHALL go DECODE->DONE if halt_instr=1, else DECODE->EXEC; halt SHALL take priority over branch.
- REQ-019 SHALL go EXEC->MEM if mem_access=1, else EXEC->WB; MEM->WB unconditionally.
- REQ-020 SHALL assert mem_we_gate only in MEM, reg_we_gate only in WB.
- REQ-021 In WB SHALL set pc<=branch_target if branch & branch_taken, else pc<=pc+1 modulo 2^PC_W (all-ones wraps to 0), then go to FETCH.
- REQ-022 SHALL increment instr_count in WB, saturating at all-ones; halt SHALL NOT be counted.
- REQ-023 Latency: non-memory instruction 4 cycles FETCH-to-FETCH, memory instruction 5.
- REQ-024 SHALL hold done=1 in DONE; DONE->IDLE only when req=0; req held high SHALL keep DONE.
- REQ-025 SHALL ignore req in every state except IDLE and DONE.
- REQ-026 pc and instr_count SHALL hold their values in IDLE and DONE.

Reset
- REQ-027 On reset=1 (any state, mid-instruction included) SHALL immediately force IDLE, pc=0, instr_count=0, done=0, fetch_en=0, reg_we_gate=0, mem_we_gate=0.
- REQ-028 First req after reset deassertion SHALL be honoured on the next rising edge.

Configuration
- REQ-029 Macro PC_SEQUENCER_STEP_EN SHALL add input step (1 bit) and state PAUSE.
- REQ-030 With macro: WB->PAUSE; PAUSE->FETCH on step=1; reset applies in PAUSE; done=0 in PAUSE.
- REQ-031 Without macro: no step port, no PAUSE; WB->FETCH directly.

Structure
- REQ-032 Package seq_pkg SHALL hold the state enum type and default PC_W/CNT_W constants.
- REQ-033 Sub-module prog_counter SHALL hold pc register, load, increment-with-wrap and branch mux.

Verification
- REQ-034 reset mid-EXEC with pc=0x05 -> next cycle IDLE, pc=0, all gates 0, done=0.
- REQ-035 start_addr=0x010, three ALU ops then halt -> done after 3x4+2 cycles, pc=0x013, instr_count=3.
- REQ-036 store at pc=0x020 -> mem_we_gate high exactly one cycle, reg_we_gate high next cycle, pc=0x021.
- REQ-037 branch=1, branch_taken=1, target=0x3F0 -> pc=0x3F0; branch_taken=0 -> pc+1.
- REQ-038 pc=0x3FF non-branch -> pc=0x000; halt with branch=1 asserted -> DONE, pc unchanged.
- REQ-039 req held high after done -> stays DONE; drop req -> IDLE; with PC_SEQUENCER_STEP_EN, no step -> PAUSE held, pc stable.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and default widths for the multi-cycle PC sequencer.
// Optional single-step PAUSE state is enabled by PC_SEQUENCER_STEP_EN.
package seq_pkg;

    localparam int unsigned PC_W_DEF  = 10;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StDone
`ifdef PC_SEQUENCER_STEP_EN
        ,
        StPause
`endif
    } seq_state_e;

endpackage

// File: rtl/prog_counter.sv
// Program counter register: start-address load, branch mux and wrapping increment.
module prog_counter
    import seq_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic [PC_W-1:0] load_addr_i,
    input  logic            advance_i,
    input  logic            take_branch_i,
    input  logic [PC_W-1:0] branch_target_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (advance_i) begin
            // Natural overflow of the PC_W-bit add gives the all-ones -> 0 wrap.
            pc_d = take_branch_i ? branch_target_i : pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer with retired-instruction counter.
// Defining PC_SEQUENCER_STEP_EN adds a step input and a PAUSE state after WB.
module pc_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [PC_W-1:0]  start_addr,
    input  logic             branch,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             mem_access,
    input  logic             halt_instr,
`ifdef PC_SEQUENCER_STEP_EN
    input  logic             step,
`endif
    output logic [PC_W-1:0]  pc,
    output logic             fetch_en,
    output logic             reg_we_gate,
    output logic             mem_we_gate,
    output logic             done,
    output logic [CNT_W-1:0] instr_count
);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pc_load;
    logic             pc_advance;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_load     = 1'b0;
        pc_advance  = 1'b0;
        fetch_en    = 1'b0;
        reg_we_gate = 1'b0;
        mem_we_gate = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StFetch;
                    pc_load = 1'b1;
                    cnt_d   = '0;
                end
            end
            StFetch: begin
                fetch_en = 1'b1;
                state_d  = StDecode;
            end
            // Halt wins over branch: it leaves before WB, so pc is never updated.
            StDecode: state_d = halt_instr ? StDone : StExec;
            StExec:   state_d = mem_access ? StMem : StWb;
            StMem: begin
                mem_we_gate = 1'b1;
                state_d     = StWb;
            end
            StWb: begin
                reg_we_gate = 1'b1;
                pc_advance  = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`ifdef PC_SEQUENCER_STEP_EN
                state_d = StPause;
`else
                state_d = StFetch;
`endif
            end
            StDone: begin
                done = 1'b1;
                if (!req) begin
                    state_d = StIdle;
                end
            end
`ifdef PC_SEQUENCER_STEP_EN
            StPause: begin
                if (step) begin
                    state_d = StFetch;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    prog_counter #(
        .PC_W(PC_W)
    ) u_prog_counter (
        .clk            (clk),
        .reset          (reset),
        .load_i         (pc_load),
        .load_addr_i    (start_addr),
        .advance_i      (pc_advance),
        .take_branch_i  (branch & branch_taken),
        .branch_target_i(branch_target),
        .pc_o           (pc)
    );

    assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default and PC_SEQUENCER_STEP_EN builds).
module tb_pc_sequencer;

    localparam int PC_W  = 10;
    localparam int CNT_W = 16;
`ifdef PC_SEQUENCER_STEP_EN
    localparam int Extra = 1;
`else
    localparam int Extra = 0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             req;
    logic [PC_W-1:0]  start_addr;
    logic             branch;
    logic             branch_taken;
    logic [PC_W-1:0]  branch_target;
    logic             mem_access;
    logic             halt_instr;
`ifdef PC_SEQUENCER_STEP_EN
    logic             step;
`endif
    logic [PC_W-1:0]  pc;
    logic             fetch_en;
    logic             reg_we_gate;
    logic             mem_we_gate;
    logic             done;
    logic [CNT_W-1:0] instr_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_W (PC_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .start_addr   (start_addr),
        .branch       (branch),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .mem_access   (mem_access),
        .halt_instr   (halt_instr),
`ifdef PC_SEQUENCER_STEP_EN
        .step         (step),
`endif
        .pc           (pc),
        .fetch_en     (fetch_en),
        .reg_we_gate  (reg_we_gate),
        .mem_we_gate  (mem_we_gate),
        .done         (done),
        .instr_count  (instr_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req           = 1'b0;
        start_addr    = '0;
        branch        = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        mem_access    = 1'b0;
        halt_instr    = 1'b0;
`ifdef PC_SEQUENCER_STEP_EN
        step          = 1'b1;
`endif
    endtask

    task automatic hard_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Leaves the DUT in FETCH of the first instruction.
    task automatic start_prog(input logic [PC_W-1:0] addr);
        start_addr = addr;
        req        = 1'b1;
        tick();
        req        = 1'b0;
    endtask

    // From FETCH, executes one instruction and returns at the next FETCH.
    task automatic run_instr(input logic mem, input logic br, input logic tk,
                             input logic [PC_W-1:0] tgt);
        mem_access    = mem;
        branch        = br;
        branch_taken  = tk;
        branch_target = tgt;
        halt_instr    = 1'b0;
        repeat (4 + int'(mem) + Extra) tick();
        mem_access    = 1'b0;
        branch        = 1'b0;
        branch_taken  = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b1;
        #2;
        checks++;
        if (pc !== 10'h000 || instr_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset_regs: pc=%h cnt=%h required pc=000 cnt=0000", pc, instr_count);
        end
        checks++;
        if ({done, fetch_en, reg_we_gate, mem_we_gate} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outs: done/fe/rwe/mwe=%b required 0000",
                     {done, fetch_en, reg_we_gate, mem_we_gate});
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (fetch_en !== 1'b0 || pc !== 10'h000) begin
            errors++;
            $display("FAIL idle_no_req: fe=%b pc=%h required fe=0 pc=000", fetch_en, pc);
        end
    endtask

    task automatic test_reset_mid_exec;
        hard_reset();
        start_prog(10'h004);
        run_instr(1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        checks++;
        if (pc !== 10'h005 || instr_count !== 16'd1) begin
            errors++;
            $display("FAIL exec_pre_reset: pc=%h cnt=%0d required pc=005 cnt=1", pc, instr_count);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (pc !== 10'h000 || instr_count !== 16'd0 ||
            {done, fetch_en, reg_we_gate, mem_we_gate} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset_exec: pc=%h cnt=%0d outs=%b required pc=000 cnt=0 outs=0000",
                     pc, instr_count, {done, fetch_en, reg_we_gate, mem_we_gate});
        end
        tick();
        reset      = 1'b0;
        start_addr = 10'h2AA;
        req        = 1'b1;
        tick();
        req = 1'b0;
        checks++;
        if (fetch_en !== 1'b1 || pc !== 10'h2AA) begin
            errors++;
            $display("FAIL first_req_after_reset: fe=%b pc=%h required fe=1 pc=2aa", fetch_en, pc);
        end
    endtask

    task automatic test_alu_program;
        int cyc;
        int fetches;
        hard_reset();
        start_prog(10'h010);
        cyc     = 0;
        fetches = 1;
        while (!done && cyc < 60) begin
            halt_instr = (fetches == 4);
            tick();
            cyc++;
            if (fetch_en) fetches++;
        end
        halt_instr = 1'b0;
        checks++;
        if (done !== 1'b1 || cyc != 14 + 3 * Extra) begin
            errors++;
            $display("FAIL alu_done_latency: done=%b cycles=%0d required done=1 cycles=%0d",
                     done, cyc, 14 + 3 * Extra);
        end
        checks++;
        if (pc !== 10'h013 || instr_count !== 16'd3 || fetches != 4) begin
            errors++;
            $display("FAIL alu_final: pc=%h cnt=%0d fetches=%0d required pc=013 cnt=3 fetches=4",
                     pc, instr_count, fetches);
        end
        tick();
    endtask

    task automatic test_store;
        logic [3:0] mw;
        logic [3:0] rw;
        hard_reset();
        start_prog(10'h020);
        mem_access = 1'b1;
        // req in mid-instruction states must not reload pc
        start_addr = 10'h155;
        req        = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            mw[i] = mem_we_gate;
            rw[i] = reg_we_gate;
        end
        req        = 1'b0;
        mem_access = 1'b0;
        checks++;
        if (mw !== 4'b0100 || rw !== 4'b1000) begin
            errors++;
            $display("FAIL store_gates: mwe=%b rwe=%b required mwe=0100 rwe=1000", mw, rw);
        end
        repeat (1 + Extra) tick();
        checks++;
        if (pc !== 10'h021 || fetch_en !== 1'b1 || instr_count !== 16'd1) begin
            errors++;
            $display("FAIL store_next: pc=%h fe=%b cnt=%0d required pc=021 fe=1 cnt=1",
                     pc, fetch_en, instr_count);
        end
    endtask

    task automatic test_branch;
        hard_reset();
        start_prog(10'h005);
        run_instr(1'b0, 1'b1, 1'b1, 10'h3F0);
        checks++;
        if (pc !== 10'h3F0 || fetch_en !== 1'b1) begin
            errors++;
            $display("FAIL branch_taken: pc=%h fe=%b required pc=3f0 fe=1", pc, fetch_en);
        end
        run_instr(1'b0, 1'b1, 1'b0, 10'h0AA);
        checks++;
        if (pc !== 10'h3F1) begin
            errors++;
            $display("FAIL branch_not_taken: pc=%h required 3f1", pc);
        end
        run_instr(1'b1, 1'b1, 1'b1, 10'h07C);
        checks++;
        if (pc !== 10'h07C || instr_count !== 16'd3) begin
            errors++;
            $display("FAIL branch_mem: pc=%h cnt=%0d required pc=07c cnt=3", pc, instr_count);
        end
    endtask

    task automatic test_wrap_and_halt;
        hard_reset();
        start_prog(10'h3FF);
        run_instr(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (pc !== 10'h000 || instr_count !== 16'd1) begin
            errors++;
            $display("FAIL pc_wrap: pc=%h cnt=%0d required pc=000 cnt=1", pc, instr_count);
        end
        halt_instr    = 1'b1;
        branch        = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 10'h123;
        tick();
        tick();
        halt_instr   = 1'b0;
        branch       = 1'b0;
        branch_taken = 1'b0;
        checks++;
        if (done !== 1'b1 || pc !== 10'h000 || instr_count !== 16'd1) begin
            errors++;
            $display("FAIL halt_over_branch: done=%b pc=%h cnt=%0d required done=1 pc=000 cnt=1",
                     done, pc, instr_count);
        end
    endtask

    // Continues from the DONE state left by test_wrap_and_halt.
    task automatic test_done_hold;
        int held;
        req  = 1'b1;
        held = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1 && fetch_en === 1'b0 && pc === 10'h000) held++;
        end
        checks++;
        if (held != 3) begin
            errors++;
            $display("FAIL done_hold_req: held=%0d required 3", held);
        end
        req = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0 || fetch_en !== 1'b0 || pc !== 10'h000 || instr_count !== 16'd1) begin
            errors++;
            $display("FAIL done_to_idle: done=%b fe=%b pc=%h cnt=%0d required 0 0 000 1",
                     done, fetch_en, pc, instr_count);
        end
        tick();
        checks++;
        if (fetch_en !== 1'b0 || pc !== 10'h000) begin
            errors++;
            $display("FAIL idle_hold: fe=%b pc=%h required fe=0 pc=000", fetch_en, pc);
        end
    endtask

    task automatic test_pause;
`ifdef PC_SEQUENCER_STEP_EN
        int stable;
        hard_reset();
        start_prog(10'h040);
        step = 1'b0;
        repeat (4) tick();
        stable = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pc === 10'h041 && fetch_en === 1'b0 && done === 1'b0) stable++;
        end
        checks++;
        if (stable != 5) begin
            errors++;
            $display("FAIL pause_hold: stable=%0d required 5", stable);
        end
        step = 1'b1;
        tick();
        checks++;
        if (fetch_en !== 1'b1 || pc !== 10'h041) begin
            errors++;
            $display("FAIL pause_step: fe=%b pc=%h required fe=1 pc=041", fetch_en, pc);
        end
`endif
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        test_reset();
        test_reset_mid_exec();
        test_alu_program();
        test_store();
        test_branch();
        test_wrap_and_halt();
        test_done_hold();
        test_pause();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
